sapho_boot_ctrl: RTL
====================

# sapho_boot_ctrl

Run controller that sequences a SAPHO processor core. Receives a program image over a byte-wide valid/ready host stream, writes it into instruction memory, and holds the core in reset until loading completes. It then releases the core, detects the halt (the core spinning on a halt address), and re-asserts core reset. Sits between the host link (UART/JTAG bridge) and the core's `rst` input and instruction-memory write port.

## Interface
- `NBINST`, 15: instruction word width; must match the core.
- `MINSTW`, 9: instruction address width.
- `NBYTES`, `(NBINST+7)/8`: bytes per instruction word.
- `WDOG_CYCLES`, 65536: watchdog limit in RUN. Used only when `SAPHO_BOOT_WDOG_EN` is defined.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `host_data`, in, 8: stream byte.
- `host_valid`, in, 1: byte valid.
- `host_ready`, out, 1: byte accepted when `host_valid & host_ready`.
- `restart`, in, 1: single-cycle pulse; re-runs the loaded program.
- `halt_addr`, in, MINSTW: instruction address of the halt loop.
- `core_instr_addr`, in, MINSTW: the core's `instr_addr`.
- `core_rst`, out, 1: drives the core's `rst`.
- `imem_we`, out, 1: instruction memory write strobe.
- `imem_waddr`, out, MINSTW: write address.
- `imem_wdata`, out, NBINST: write data.
- `running`, out, 1: high in RUN.
- `halted`, out, 1: high in HALT.
- `timeout`, out, 1: sticky flag; watchdog expired.

## Operation
- States: IDLE, HDR1, LOAD, RUN, HALT.
- Stream format: 16-bit word count N, little-endian (2 bytes). Then N words, each NBYTES bytes, little-endian. Bits above NBINST-1 of the assembled word are discarded.
- IDLE: `host_ready=1`. An accepted byte becomes count[7:0]; go to HDR1.
- HDR1: `host_ready=1`. An accepted byte becomes count[15:8].
  - Count 0: go to RUN.
  - Otherwise: clear the word address and byte index; go to LOAD.
- LOAD: `host_ready=1`. Each accepted byte fills byte slot `byte_idx`.
  - On the last byte of a word, register the write (`imem_we`, `imem_waddr`, `imem_wdata`) for the next cycle.
  - After that, increment the address (wraps modulo 2^MINSTW) and decrement the remaining count.
  - When the remaining count reaches 0, go to RUN.
- RUN: `core_rst=0`, `host_ready=0`.
  - HALT is detected when `core_instr_addr == halt_addr` for 2 consecutive cycles. Then go to HALT.
- HALT: `core_rst=1`, `halted=1`, `host_ready=1`. An accepted byte is count[7:0] of a new image; go to HDR1.
- `restart` in RUN or HALT:
  - Assert `core_rst` for exactly 1 cycle, then RUN.
  - The halt detector and watchdog counter clear.
  - `restart` is ignored in IDLE, HDR1 and LOAD.
- `core_rst=1` in every state except RUN.
- Reset values: state IDLE, `core_rst=1`, `imem_we=0`, `imem_waddr=0`, `imem_wdata=0`, `host_ready=0` for the first cycle after reset release (then 1), `running=0`, `halted=0`, `timeout=0`.

## Timing
- Byte handshake: one byte per cycle maximum; `host_ready` is registered.
- Write latency: `imem_we` is high for exactly 1 cycle, the cycle after the last byte of the word is accepted.
- RUN entry: `core_rst` falls the cycle after the final `imem_we` pulse. This ordering guarantees the last word is in memory before the core's first fetch.
- Halt latency: `halted` rises 1 cycle after the second consecutive match. `core_rst` rises in the same cycle.
- `restart` and halt detection in the same cycle: `restart` wins; stay in RUN.
- `rst` mid-LOAD: the partial image is abandoned and no further writes occur. Memory contents are undefined until the next load.
- `host_valid` with `host_ready=0` is held by the host; no byte is lost.

## Configuration
- `SAPHO_BOOT_WDOG_EN` defined:
  - A counter runs in RUN and clears on RUN entry and on `restart`.
  - Reaching WDOG_CYCLES forces HALT and sets `timeout`.
  - `timeout` clears only on `rst` or on the next accepted header byte.
- Not defined: no counter is built, `timeout` is tied to 0, and RUN ends only through halt detection or `rst`.

## Test plan
- Load N=3, words 0x1234/0x0055/0x7FFF (bytes 03 00 34 12 55 00 FF 7F) -> writes to addresses 0,1,2 with those values, then `core_rst` falls 1 cycle after the third `imem_we`.
- Count 0 (bytes 00 00) -> no `imem_we`; RUN the cycle after HDR1 accepts.
- RUN with `halt_addr=0x1F0`: `core_instr_addr` = 0x1F0 for 1 cycle, then 0x1F1, then 0x1F0 for 2 cycles -> no halt on the single match; `halted=1` and `core_rst=1` after the pair.
- `host_valid` toggling every other cycle during LOAD, N=2 -> correct words at addresses 0,1; no duplicate strobes.
- `restart` in HALT -> `core_rst` low 2 cycles later, `running=1`; coincident `restart` and halt match in RUN -> stays RUN.
- With `SAPHO_BOOT_WDOG_EN`, WDOG_CYCLES=16, no halt -> HALT and `timeout=1` after 16 RUN cycles; `timeout` clears on the next header byte.

Source files
------------

// File: rtl/sapho_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sapho_boot_ctrl
// Description : Run controller for a SAPHO processor core.
//               - Accepts a program image over a byte-wide valid/ready stream:
//                 16-bit little-endian word count N, then N words of NBYTES
//                 bytes each, little-endian.
//               - Writes each assembled word into instruction memory.
//               - Holds the core in reset while loading, then releases it.
//               - Detects the halt loop (two consecutive fetches from
//                 halt_addr) and puts the core back into reset.
//               - Optional watchdog: define SAPHO_BOOT_WDOG_EN to build a RUN
//                 cycle counter that forces HALT and sets the sticky timeout.
// Ports       : clk, rst (async, active-high)
//               host_data/host_valid/host_ready : image byte stream
//               restart                         : re-run the loaded program
//               halt_addr, core_instr_addr      : halt detection
//               core_rst                        : core reset output
//               imem_we/imem_waddr/imem_wdata   : instruction memory write
//               running, halted, timeout        : status
// Revision    : 1.0 - initial release
// ============================================================================
module sapho_boot_ctrl #(
    parameter int NBINST      = 15,
    parameter int MINSTW      = 9,
    parameter int NBYTES      = (NBINST + 7) / 8,
    parameter int WDOG_CYCLES = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        host_data,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              restart,
    input  logic [MINSTW-1:0] halt_addr,
    input  logic [MINSTW-1:0] core_instr_addr,
    output logic              core_rst,
    output logic              imem_we,
    output logic [MINSTW-1:0] imem_waddr,
    output logic [NBINST-1:0] imem_wdata,
    output logic              running,
    output logic              halted,
    output logic              timeout
);

    localparam int c_IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int c_BUF_W = NBYTES * 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR1 = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_host_ready;
    logic                r_core_rst;
    logic                r_imem_we;
    logic [MINSTW-1:0]   r_imem_waddr;
    logic [NBINST-1:0]   r_imem_wdata;
    logic                r_running;
    logic                r_halted;
    logic [7:0]          r_count_lo;
    logic [15:0]         r_remaining;
    logic [MINSTW-1:0]   r_addr;
    logic [c_IDX_W-1:0]  r_byte_idx;
    logic [c_BUF_W-1:0]  r_buf;
    logic                r_match_prev;

    logic                w_accept;
    logic                w_match;
    logic                w_wdog_expired;
    logic [c_BUF_W-1:0]  w_assembled;

    assign w_accept = host_valid & r_host_ready;
    assign w_match  = (core_instr_addr == halt_addr);

    // Current word with the incoming byte dropped into its slot.
    always_comb begin
        w_assembled = r_buf;
        w_assembled[{r_byte_idx, 3'b000} +: 8] = host_data;
    end

    // Main sequencer. core_rst is only ever cleared from inside RUN, so every
    // entry into RUN keeps the core in reset for one extra cycle: this places
    // the final imem_we pulse strictly before the core's first fetch, and
    // gives restart its single-cycle reset pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_host_ready <= 1'b0;
            r_core_rst   <= 1'b1;
            r_imem_we    <= 1'b0;
            r_imem_waddr <= '0;
            r_imem_wdata <= '0;
            r_running    <= 1'b0;
            r_halted     <= 1'b0;
            r_count_lo   <= '0;
            r_remaining  <= '0;
            r_addr       <= '0;
            r_byte_idx   <= '0;
            r_buf        <= '0;
            r_match_prev <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_host_ready <= 1'b1;
                    if (w_accept) begin
                        r_count_lo <= host_data;
                        r_state    <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (w_accept) begin
                        if ({host_data, r_count_lo} == 16'd0) begin
                            r_state      <= S_RUN;
                            r_running    <= 1'b1;
                            r_host_ready <= 1'b0;
                            r_match_prev <= 1'b0;
                        end else begin
                            r_remaining <= {host_data, r_count_lo};
                            r_addr      <= '0;
                            r_byte_idx  <= '0;
                            r_state     <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (r_byte_idx == c_IDX_W'(NBYTES - 1)) begin
                            r_imem_we    <= 1'b1;
                            r_imem_waddr <= r_addr;
                            r_imem_wdata <= w_assembled[NBINST-1:0];
                            r_addr       <= r_addr + MINSTW'(1);
                            r_remaining  <= r_remaining - 16'd1;
                            r_byte_idx   <= '0;
                            if (r_remaining == 16'd1) begin
                                r_state      <= S_RUN;
                                r_running    <= 1'b1;
                                r_host_ready <= 1'b0;
                                r_match_prev <= 1'b0;
                            end
                        end else begin
                            r_buf      <= w_assembled;
                            r_byte_idx <= r_byte_idx + c_IDX_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    // restart outranks both halt detection and the watchdog.
                    if (restart) begin
                        r_core_rst   <= 1'b1;
                        r_match_prev <= 1'b0;
                    end else if ((w_match && r_match_prev) || w_wdog_expired) begin
                        r_state      <= S_HALT;
                        r_core_rst   <= 1'b1;
                        r_running    <= 1'b0;
                        r_halted     <= 1'b1;
                        r_host_ready <= 1'b1;
                        r_match_prev <= 1'b0;
                    end else begin
                        r_core_rst   <= 1'b0;
                        r_match_prev <= w_match;
                    end
                end
                S_HALT: begin
                    // A restart coinciding with a host byte takes priority;
                    // the host is expected not to stream while restarting.
                    if (restart) begin
                        r_state      <= S_RUN;
                        r_running    <= 1'b1;
                        r_halted     <= 1'b0;
                        r_host_ready <= 1'b0;
                        r_match_prev <= 1'b0;
                    end else if (w_accept) begin
                        r_count_lo <= host_data;
                        r_halted   <= 1'b0;
                        r_state    <= S_HDR1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_core_rst   <= 1'b1;
                    r_running    <= 1'b0;
                    r_halted     <= 1'b0;
                    r_host_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef SAPHO_BOOT_WDOG_EN
    localparam int c_WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [c_WDOG_W-1:0] r_wdog;
    logic                r_timeout;

    // Fires in the WDOG_CYCLES-th consecutive RUN cycle since entry/restart.
    assign w_wdog_expired = (r_state == S_RUN) && !restart &&
                            (r_wdog == c_WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state != S_RUN) || restart) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + c_WDOG_W'(1);
            end
            if (w_wdog_expired) begin
                r_timeout <= 1'b1;
            end else if (w_accept && ((r_state == S_IDLE) || (r_state == S_HALT))) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_wdog;
    assign w_unused_wdog  = ^WDOG_CYCLES;
    assign w_wdog_expired = 1'b0;
    assign timeout        = 1'b0;
`endif

    assign host_ready = r_host_ready;
    assign core_rst   = r_core_rst;
    assign imem_we    = r_imem_we;
    assign imem_waddr = r_imem_waddr;
    assign imem_wdata = r_imem_wdata;
    assign running    = r_running;
    assign halted     = r_halted;

endmodule
`default_nettype wire
